// File: rtl/fixed_add_subt_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fixed_add_subt_unit
//  Purpose  : Multi-cycle signed fixed-point add/subtract responder for the
//             beg/ready/ack handshake of the CORDIC control FSM. Operands are
//             captured on a start request, summed CHUNK bits per cycle with a
//             registered carry, and the result saturates on two's-complement
//             overflow. The result is held with ready high until acknowledged.
//  Ports    : clk            - system clock, rising edge
//             reset          - asynchronous, active-low reset
//             beg_add_subt   - start request (sampled in IDLE only)
//             ack_add_subt   - result taken (sampled in DONE only)
//             add_subt       - 0: X+Y, 1: X-Y (captured with operands)
//             Data_X, Data_Y - W-bit two's-complement operands
//             ready_add_subt - high exactly while in DONE
//             busy           - high in EXEC and CHECK
//             result         - saturated sum, held through DONE
//             overflow_flag  - positive saturation occurred
//             underflow_flag - negative saturation occurred
//  Revision : 1.0 - initial release
// ============================================================================
module fixed_add_subt_unit #(
   parameter int W     = 32,
   parameter int CHUNK = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         beg_add_subt,
   input  logic         ack_add_subt,
   input  logic         add_subt,
   input  logic [W-1:0] Data_X,
   input  logic [W-1:0] Data_Y,
   output logic         ready_add_subt,
   output logic         busy,
   output logic [W-1:0] result,
   output logic         overflow_flag,
   output logic         underflow_flag
);

   localparam int              c_N       = W / CHUNK;
   localparam int              c_CW      = (c_N > 1) ? $clog2(c_N) : 1;
   localparam logic [c_CW-1:0] c_LAST    = c_CW'(c_N - 1);
   localparam logic [W-1:0]    c_SAT_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]    c_SAT_MIN = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EXEC  = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;

   logic [W-1:0]      r_opa;
   logic [W-1:0]      r_opb;
   logic [W-1:0]      r_sum;
   logic              r_carry;
   logic [c_CW-1:0]   r_cnt;
   logic [W-1:0]      r_result;
   logic              r_ovf;
   logic              r_unf;
   logic              r_ready;
   logic              r_busy;

   int                w_base;
   logic [CHUNK:0]    w_chunk_sum;
   logic              w_ovf;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (beg_add_subt)     w_next = S_EXEC;
         S_EXEC:  if (r_cnt == c_LAST)  w_next = S_CHECK;
         S_CHECK:                       w_next = S_DONE;
         S_DONE:  if (ack_add_subt)     w_next = S_IDLE;
         default:                       w_next = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------- datapath
   // One CHUNK-wide slice of the operands per EXEC cycle; the carry out of
   // each slice is registered and feeds the next slice.
   assign w_base      = int'(r_cnt) * CHUNK;
   assign w_chunk_sum = {1'b0, r_opa[w_base +: CHUNK]}
                      + {1'b0, r_opb[w_base +: CHUNK]}
                      + {{CHUNK{1'b0}}, r_carry};

   // Subtraction is carried as opA + ~Y + 1, so the overflow test uses the
   // already-inverted opB sign rather than Data_Y's sign.
   assign w_ovf = (r_opa[W-1] == r_opb[W-1]) && (r_sum[W-1] != r_opa[W-1]);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_opa    <= '0;
         r_opb    <= '0;
         r_sum    <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
         r_ready  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         // Handshake outputs are registered copies of the next-state decode.
         r_ready <= (w_next == S_DONE);
         r_busy  <= (w_next == S_EXEC) || (w_next == S_CHECK);

         case (r_state)
            S_IDLE: begin
               if (beg_add_subt) begin
                  r_opa   <= Data_X;
                  r_opb   <= add_subt ? ~Data_Y : Data_Y;
                  r_carry <= add_subt;
                  r_cnt   <= '0;
               end
            end
            S_EXEC: begin
               r_sum[w_base +: CHUNK] <= w_chunk_sum[CHUNK-1:0];
               r_carry                <= w_chunk_sum[CHUNK];
               r_cnt                  <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
            end
            S_CHECK: begin
               if (w_ovf && !r_opa[W-1]) begin
                  r_result <= c_SAT_MAX;
                  r_ovf    <= 1'b1;
                  r_unf    <= 1'b0;
               end else if (w_ovf) begin
                  r_result <= c_SAT_MIN;
                  r_ovf    <= 1'b0;
                  r_unf    <= 1'b1;
               end else begin
                  r_result <= r_sum;
                  r_ovf    <= 1'b0;
                  r_unf    <= 1'b0;
               end
            end
            default: begin
               // DONE holds result and flags until the next CHECK.
            end
         endcase
      end
   end

   assign ready_add_subt = r_ready;
   assign busy           = r_busy;
   assign result         = r_result;
   assign overflow_flag  = r_ovf;
   assign underflow_flag = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_fixed_add_subt_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fixed_add_subt_unit
//  Purpose  : Self-checking bench for fixed_add_subt_unit (W=32, CHUNK=8).
//             Directed handshake/saturation/reset steps followed by random
//             back-to-back operations against a saturating arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fixed_add_subt_unit;

   localparam int W   = 32;
   localparam int LAT = 5;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         beg_add_subt = 1'b0;
   logic         ack_add_subt = 1'b0;
   logic         add_subt = 1'b0;
   logic [W-1:0] Data_X = '0;
   logic [W-1:0] Data_Y = '0;
   logic         ready_add_subt;
   logic         busy;
   logic [W-1:0] result;
   logic         overflow_flag;
   logic         underflow_flag;

   int checks = 0;
   int errors = 0;

   fixed_add_subt_unit #(.W(W), .CHUNK(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .beg_add_subt   (beg_add_subt),
      .ack_add_subt   (ack_add_subt),
      .add_subt       (add_subt),
      .Data_X         (Data_X),
      .Data_Y         (Data_Y),
      .ready_add_subt (ready_add_subt),
      .busy           (busy),
      .result         (result),
      .overflow_flag  (overflow_flag),
      .underflow_flag (underflow_flag)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Saturating reference: exact signed arithmetic in 64 bits, then clamp.
   function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic sub, output logic [W-1:0] r,
                                 output logic ov, output logic un);
      longint sx, sy, s;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      s  = sub ? (sx - sy) : (sx + sy);
      ov = 1'b0;
      un = 1'b0;
      if (s > 64'sd2147483647) begin
         r  = 32'h7FFF_FFFF;
         ov = 1'b1;
      end else if (s < -64'sd2147483648) begin
         r  = 32'h8000_0000;
         un = 1'b1;
      end else begin
         r = s[31:0];
      end
   endfunction

   // Starts an operation, scrambles the inputs after capture, waits for
   // ready (bounded) and checks result, flags and latency. Leaves DONE.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic sub, input string tag);
      logic [W-1:0] er;
      logic         eo, eu;
      int           lat;
      model(x, y, sub, er, eo, eu);
      Data_X = x; Data_Y = y; add_subt = sub; beg_add_subt = 1'b1;
      tick();
      beg_add_subt = 1'b0;
      Data_X = $urandom; Data_Y = $urandom; add_subt = 1'($urandom_range(0, 1));
      lat = 0;
      while (ready_add_subt !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      chk({tag, ".result"}, result, er);
      chk({tag, ".flags"}, {30'd0, overflow_flag, underflow_flag}, {30'd0, eo, eu});
      chk({tag, ".latency"}, W'(lat), W'(LAT));
   endtask

   task automatic do_ack(input string tag);
      ack_add_subt = 1'b1;
      tick();
      ack_add_subt = 1'b0;
      chk({tag, ".ready_after_ack"}, W'(ready_add_subt), W'(0));
   endtask

   initial begin
      logic         ok;
      logic [W-1:0] held;
      int           hits;
      logic [W-1:0] rx, ry;

      // ---------------- reset state
      #12;
      chk("reset.outputs", {27'd0, ready_add_subt, busy, overflow_flag, underflow_flag, 1'b0}, W'(0));
      chk("reset.result", result, W'(0));
      tick();
      reset = 1'b1;
      tick();

      // ---------------- 5 + 7 with busy/ready timing
      Data_X = 32'd5; Data_Y = 32'd7; add_subt = 1'b0; beg_add_subt = 1'b1;
      tick();
      beg_add_subt = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < LAT; i++) begin
         if (!(busy === 1'b1 && ready_add_subt === 1'b0)) ok = 1'b0;
         tick();
      end
      chk("add.busy_window", W'(ok), W'(1));
      chk("add.ready", W'(ready_add_subt), W'(1));
      chk("add.busy_done", W'(busy), W'(0));
      chk("add.result", result, 32'h0000_000C);
      chk("add.flags", {30'd0, overflow_flag, underflow_flag}, W'(0));
      do_ack("add");

      // ---------------- carry chain and saturation corners
      run_op(32'd3, 32'd10, 1'b1, "sub3m10");        do_ack("sub3m10");
      chk("sub3m10.value", result, 32'hFFFF_FFF9);
      run_op(32'h0000_00FF, 32'd1, 1'b0, "carry");   do_ack("carry");
      chk("carry.value", result, 32'h0000_0100);
      run_op(32'h7FFF_FFFF, 32'd1, 1'b0, "satpos");
      chk("satpos.ovf", W'(overflow_flag), W'(1));

      // ---------------- hold ack low for 10 cycles
      held = result;
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ready_add_subt !== 1'b1 || result !== held || overflow_flag !== 1'b1) ok = 1'b0;
      end
      chk("hold.stable", W'(ok), W'(1));
      do_ack("hold");

      run_op(32'h8000_0000, 32'd1, 1'b1, "satneg");
      chk("satneg.unf", W'(underflow_flag), W'(1));
      do_ack("satneg");
      run_op(32'h8000_0000, 32'h8000_0000, 1'b1, "minmin"); do_ack("minmin");

      // ---------------- beg pulsed in EXEC and in DONE is ignored
      Data_X = 32'd100; Data_Y = 32'd23; add_subt = 1'b0; beg_add_subt = 1'b1;
      tick();
      beg_add_subt = 1'b0;
      tick();
      Data_X = 32'd999; beg_add_subt = 1'b1;
      tick();
      beg_add_subt = 1'b0;
      hits = 0;
      while (ready_add_subt !== 1'b1 && hits < 20) begin
         tick();
         hits++;
      end
      chk("begexec.result", result, 32'd123);
      beg_add_subt = 1'b1;
      tick();
      beg_add_subt = 1'b0;
      chk("begdone.still_ready", W'(ready_add_subt), W'(1));
      do_ack("begdone");
      hits = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (ready_add_subt !== 1'b0 || busy !== 1'b0) hits++;
      end
      chk("begdone.no_second", W'(hits), W'(0));

      // ---------------- ack and beg together in DONE: ack wins
      run_op(32'd2, 32'd3, 1'b0, "ackbeg");
      ack_add_subt = 1'b1; beg_add_subt = 1'b1;
      tick();
      ack_add_subt = 1'b0; beg_add_subt = 1'b0;
      chk("ackbeg.ready", W'(ready_add_subt), W'(0));
      tick();
      chk("ackbeg.not_queued", W'(busy), W'(0));

      // ---------------- asynchronous reset during the second EXEC cycle
      Data_X = 32'd9; Data_Y = 32'd9; add_subt = 1'b0; beg_add_subt = 1'b1;
      tick();
      beg_add_subt = 1'b0;
      tick();
      chk("rst.busy_before", W'(busy), W'(1));
      #2;
      reset = 1'b0;
      #1;
      chk("rst.outputs", {28'd0, ready_add_subt, busy, overflow_flag, underflow_flag}, W'(0));
      chk("rst.result", result, W'(0));
      tick();
      tick();
      reset = 1'b1;
      hits = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ready_add_subt !== 1'b0 || busy !== 1'b0) hits++;
      end
      chk("rst.no_ready", W'(hits), W'(0));
      run_op(32'd1, 32'd1, 1'b0, "postrst");
      chk("postrst.value", result, 32'd2);
      do_ack("postrst");

      // ---------------- random back-to-back operations
      for (int n = 0; n < 100; n++) begin
         case ($urandom_range(0, 3))
            0: begin rx = $urandom; ry = $urandom; end
            1: begin rx = 32'h7FFF_FFFF - $urandom_range(0, 15); ry = $urandom_range(0, 31); end
            2: begin rx = 32'h8000_0000 + $urandom_range(0, 15); ry = $urandom_range(0, 31); end
            default: begin rx = 32'($urandom_range(0, 1000)) - 32'd500; ry = $urandom_range(0, 1000); end
         endcase
         run_op(rx, ry, 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
         do_ack($sformatf("rand%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
